// File: rtl/ft_pkg.sv
// ft_pkg: shared types and constants for the checkpoint rollback engine.
//   state_e          - loader sequencer states
//   NUM_REGS_DEF     - default architectural register count
//   PC_WORD_IDX_DEF  - default checkpoint word index of the saved PC
//   WORD_SHIFT       - word index to byte address shift
package ft_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam int NUM_REGS_DEF    = 32;
  localparam int PC_WORD_IDX_DEF = 32;
  localparam int WORD_SHIFT      = 2;
endpackage

// File: rtl/ft_recovery_loader.sv
// ft_recovery_loader: replays a checkpointed register file and PC into the core.
// Reads one checkpoint word at a time over a req/gnt/rvalid port, writes each
// register into the RF write port and finally presents the restored PC.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   start_i / busy_o / done_o     sequencing from the fault-tolerance controller
//   error_o                       sticky memory error / timeout flag
//   data_req_o .. data_err_i      checkpoint memory read port (byte addresses)
//   rf_we_o, rf_waddr_o, rf_wdata_o  register-file write port
//   pc_o, pc_valid_o              restored PC and its one-cycle update strobe
module ft_recovery_loader
  import ft_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int PC_WORD_IDX = PC_WORD_IDX_DEF,
  parameter int SKIP_R0     = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic [31:0] data_addr_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] pc_o,
  output logic        pc_valid_o
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           error_q, error_d;
  logic           rf_we_q, rf_we_d;
  logic [4:0]     rf_waddr_q, rf_waddr_d;
  logic [31:0]    rf_wdata_q, rf_wdata_d;
  logic [31:0]    pc_q, pc_d;
  logic           pc_valid_q, pc_valid_d;

  logic           pc_slot;
  logic           tmo;
  logic [31:0]    slot_word;

  // idx==NUM_REGS is the PC slot; it maps onto its own checkpoint word.
  assign pc_slot   = (idx_q == 6'(NUM_REGS));
  assign slot_word = pc_slot ? 32'(PC_WORD_IDX) : {26'b0, idx_q};
  // Timer about to reach TIMEOUT on this cycle without progress.
  assign tmo       = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    error_d     = error_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = 5'd0;
    rf_wdata_d  = 32'd0;
    pc_d        = pc_q;
    pc_valid_d  = 1'b0;
    data_req_o  = 1'b0;
    data_addr_o = 32'd0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = (SKIP_R0 != 0) ? 6'd1 : 6'd0;
          error_d = 1'b0;
          timer_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        data_req_o  = 1'b1;
        data_addr_o = slot_word << WORD_SHIFT;
        timer_d     = timer_q + 1'b1;
        if (tmo) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else if (data_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Address held: the memory samples read data from it until rvalid.
        data_addr_o = slot_word << WORD_SHIFT;
        timer_d     = timer_q + 1'b1;
        if (data_rvalid_i) begin
          timer_d = '0;
          if (data_err_i) begin
            error_d = 1'b1;
            state_d = S_ERR;
          end else if (pc_slot) begin
            pc_d       = data_rdata_i;
            pc_valid_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            rf_we_d    = 1'b1;
            rf_waddr_d = idx_q[4:0];
            rf_wdata_d = data_rdata_i;
            idx_d      = idx_q + 1'b1;
            state_d    = S_REQ;
          end
        end else if (tmo) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      error_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pc_q       <= '0;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      error_q    <= error_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign error_o    = error_q;
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign pc_o       = pc_q;
  assign pc_valid_o = pc_valid_q;
endmodule

// File: tb/tb_ft_recovery_loader.sv
// Directed bench for ft_recovery_loader: two instances (SKIP_R0=1 and 0), each
// with a checkpoint memory model (reg k = 0x1000_0000+k, PC = 0x200) and a
// negedge monitor that logs write/PC/done/error timing relative to start.
module tb_ft_recovery_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic [5:0] stall_idx = 6'd63, rvd_idx = 6'd63, err_idx = 6'd63, ng_idx = 6'd63;
  int stall_n = 0, rvd_n = 0;
  int vecs = 0, miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    logic busy, done, err, req, gnt, rv, derr, we, pcv, st;
    logic [31:0] addr, rdata, wdata, pc;
    logic [4:0] waddr;
    logic [5:0] widx;
    assign st   = (g == 0) ? start0 : start1;
    assign widx = addr[7:2];

    ft_recovery_loader #(.SKIP_R0((g == 0) ? 1 : 0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(st), .busy_o(busy), .done_o(done),
      .error_o(err), .data_req_o(req), .data_gnt_i(gnt), .data_rvalid_i(rv),
      .data_addr_o(addr), .data_rdata_i(rdata), .data_err_i(derr),
      .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
      .pc_o(pc), .pc_valid_o(pcv)
    );

    // Memory model: grant same cycle (unless stalled/blocked), data one cycle
    // later plus an optional extra delay for one word.
    logic pend;
    logic [5:0] pidx;
    int dly, stall_cnt;
    assign gnt   = req && (widx != ng_idx) && !(widx == stall_idx && stall_cnt < stall_n);
    assign rv    = pend && (dly == 0);
    assign rdata = rv ? ((pidx == 6'd32) ? 32'h0000_0200 : 32'h1000_0000 + 32'(pidx)) : 32'h0;
    assign derr  = rv && (pidx == err_idx);

    always @(posedge clk) begin
      if (clr) begin
        pend <= 1'b0; pidx <= '0; dly <= 0; stall_cnt <= 0;
      end else begin
        if (req && !gnt && widx == stall_idx) stall_cnt <= stall_cnt + 1;
        if (rv) pend <= 1'b0;
        else if (pend) dly <= dly - 1;
        if (req && gnt) begin
          pend <= 1'b1;
          pidx <= widx;
          dly  <= (widx == rvd_idx) ? rvd_n : 0;
        end
      end
    end

    // Monitor: rel counts cycles since the accepted start (start cycle = 0).
    int rel, wr_n, wr_bad, first_wr_cyc, first_waddr, last_wr_cyc, pcv_n, pc_cyc;
    int done_n, done_cyc, busy_fall, err_cyc, rd_n, addr_bad, overlap, req_err;
    int first_req_addr, exp_next;
    logic busy_p, err_p, req_p, gnt_p;
    logic [31:0] addr_p;
    always @(negedge clk) begin
      if (clr) begin
        rel <= 0; wr_n <= 0; wr_bad <= 0; first_wr_cyc <= -1; first_waddr <= -1;
        last_wr_cyc <= -1; pcv_n <= 0; pc_cyc <= -1; done_n <= 0; done_cyc <= -1;
        busy_fall <= -1; err_cyc <= -1; rd_n <= 0; addr_bad <= 0; overlap <= 0;
        req_err <= 0; first_req_addr <= -1; exp_next <= (g == 0) ? 1 : 0;
        busy_p <= busy; err_p <= err; req_p <= 1'b0; gnt_p <= 1'b0; addr_p <= '0;
      end else begin
        rel <= (st && !busy) ? 0 : rel + 1;
        busy_p <= busy; err_p <= err; req_p <= req; gnt_p <= gnt; addr_p <= addr;
        if (we) begin
          wr_n <= wr_n + 1;
          last_wr_cyc <= rel + 1;
          if (wr_n == 0) begin
            first_wr_cyc <= rel + 1;
            first_waddr  <= int'(waddr);
          end
          if (waddr != 5'(exp_next) || wdata != 32'h1000_0000 + 32'(waddr))
            wr_bad <= wr_bad + 1;
          exp_next <= exp_next + 1;
        end
        if (pcv) begin
          pcv_n <= pcv_n + 1; pc_cyc <= rel + 1;
          if (we) overlap <= overlap + 1;
        end
        if (done) begin done_n <= done_n + 1; done_cyc <= rel + 1; end
        if (busy_p && !busy) busy_fall <= rel + 1;
        if (err && !err_p) err_cyc <= rel + 1;
        if (req && err) req_err <= req_err + 1;
        if (req && gnt) begin
          rd_n <= rd_n + 1;
          if (rd_n == 0) first_req_addr <= int'(addr);
        end
        if (pend && addr != {24'b0, pidx, 2'b00}) addr_bad <= addr_bad + 1;
        if (req && req_p && !gnt_p && addr != addr_p) addr_bad <= addr_bad + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clear model/monitor, pulse start on instance g, optionally pulse start
  // again at cycle 'extra' (while busy), then wait for idle with a bound.
  task automatic run(input int g, input int extra);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0; start0 = (g == 0); start1 = (g == 1);
    @(posedge clk); #1 start0 = 1'b0; start1 = 1'b0;
    if (extra > 0) begin
      repeat (extra - 1) @(posedge clk);
      #1 start0 = (g == 0); start1 = (g == 1);
      @(posedge clk); #1 start0 = 1'b0; start1 = 1'b0;
    end
    for (int i = 0; i < 300; i++) begin
      if (!((g == 0) ? gi[0].busy : gi[1].busy)) break;
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    chk("run_reaches_idle", (g == 0) ? gi[0].busy : gi[1].busy, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", gi[0].busy, 0);
    chk("rst_done", gi[0].done, 0);
    chk("rst_err", gi[0].err, 0);
    chk("rst_req", gi[0].req, 0);
    chk("rst_we", gi[0].we, 0);
    chk("rst_pcv", gi[0].pcv, 0);
    chk("rst_pc", gi[0].pc, 0);
    chk("rst_addr", gi[0].addr, 0);
    rst_n = 1'b1;

    // Default recovery, with a stray start at cycle 10 that must be ignored.
    run(0, 10);
    chk("t1_wr_n", gi[0].wr_n, 31);
    chk("t1_wr_bad", gi[0].wr_bad, 0);
    chk("t1_first_waddr", gi[0].first_waddr, 1);
    chk("t1_first_wr_cyc", gi[0].first_wr_cyc, 3);
    chk("t1_last_wr_cyc", gi[0].last_wr_cyc, 63);
    chk("t1_rd_n", gi[0].rd_n, 32);
    chk("t1_pc", gi[0].pc, 32'h200);
    chk("t1_pcv_n", gi[0].pcv_n, 1);
    chk("t1_pc_cyc", gi[0].pc_cyc, 65);
    chk("t1_done_n", gi[0].done_n, 1);
    chk("t1_done_cyc", gi[0].done_cyc, 65);
    chk("t1_busy_fall", gi[0].busy_fall, 66);
    chk("t1_err", gi[0].err, 0);
    chk("t1_overlap", gi[0].overlap, 0);
    chk("t1_addr_bad", gi[0].addr_bad, 0);

    // SKIP_R0=0 instance: r0 is read and written first.
    run(1, 0);
    chk("t2_first_req_addr", gi[1].first_req_addr, 0);
    chk("t2_first_waddr", gi[1].first_waddr, 0);
    chk("t2_wr_n", gi[1].wr_n, 32);
    chk("t2_rd_n", gi[1].rd_n, 33);
    chk("t2_wr_bad", gi[1].wr_bad, 0);
    chk("t2_done_n", gi[1].done_n, 1);

    // Grant stall of 3 on reg 5, rvalid delay of 2 on reg 9: +5 cycles.
    stall_idx = 6'd5; stall_n = 3; rvd_idx = 6'd9; rvd_n = 2;
    run(0, 0);
    chk("t3_wr_n", gi[0].wr_n, 31);
    chk("t3_wr_bad", gi[0].wr_bad, 0);
    chk("t3_addr_bad", gi[0].addr_bad, 0);
    chk("t3_pc", gi[0].pc, 32'h200);
    chk("t3_done_cyc", gi[0].done_cyc, 70);
    chk("t3_busy_fall", gi[0].busy_fall, 71);
    stall_idx = 6'd63; stall_n = 0; rvd_idx = 6'd63; rvd_n = 0;

    // Memory error on reg 7: r1..r6 written, error sticky, no done.
    err_idx = 6'd7;
    run(0, 0);
    chk("t4_wr_n", gi[0].wr_n, 6);
    chk("t4_err_cyc", gi[0].err_cyc, 15);
    chk("t4_busy_fall", gi[0].busy_fall, 16);
    chk("t4_done_n", gi[0].done_n, 0);
    chk("t4_pcv_n", gi[0].pcv_n, 0);
    repeat (5) @(posedge clk);
    #1 chk("t4_err_sticky", gi[0].err, 1);
    err_idx = 6'd63;
    run(0, 0);
    chk("t4b_err_cleared", gi[0].err, 0);
    chk("t4b_wr_n", gi[0].wr_n, 31);
    chk("t4b_done_n", gi[0].done_n, 1);

    // Grant never given for reg 3: REQ entered at cycle 5, error at 5+16.
    ng_idx = 6'd3;
    run(0, 0);
    chk("t5_wr_n", gi[0].wr_n, 2);
    chk("t5_err_cyc", gi[0].err_cyc, 21);
    chk("t5_req_with_err", gi[0].req_err, 0);
    chk("t5_busy_fall", gi[0].busy_fall, 22);
    chk("t5_done_n", gi[0].done_n, 0);
    ng_idx = 6'd63;

    // Reset at cycle 20 mid-sequence (r1..r9 already written).
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy", gi[0].busy, 0);
    chk("t6_req", gi[0].req, 0);
    chk("t6_addr", gi[0].addr, 0);
    chk("t6_we", gi[0].we, 0);
    chk("t6_pc", gi[0].pc, 0);
    chk("t6_err", gi[0].err, 0);
    chk("t6_wr_n_before", gi[0].wr_n, 9);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_wr_n_after", gi[0].wr_n, 9);
    chk("t6_idle_after", gi[0].busy, 0);
    chk("t6_done_n", gi[0].done_n, 0);
    chk("t6_pcv_n", gi[0].pcv_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000");
    $fatal(1);
  end
endmodule
